postadder_seq: RTL and testbench

- Command sequencer for the BN254 post-adder.
- Accepts per-thread accumulate commands from up to four threads into small per-thread FIFOs.
- Picks one thread per cycle by round-robin and drives the post-adder control bus: mode1/2/3, addr2/3, thread, outsel.
- Tracks the post-adder's 2-cycle output latency so downstream logic gets a qualified result strobe tagged with its thread.

---
 rtl/postadder_seq_if.sv | 31 +++
 rtl/postadder_seq.sv | 121 ++++++++++++
 tb/tb_postadder_seq.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/postadder_seq_if.sv
// postadder_seq_if: command handshake and post-adder control bus of the sequencer
interface postadder_seq_if;
    logic        cmd_valid;
    logic [1:0]  cmd_thread;
    logic [15:0] cmd_data;
    logic        cmd_ready;
    logic        stall;
    logic [2:0]  mode1;
    logic [2:0]  mode2;
    logic [2:0]  mode3;
    logic [1:0]  addr2;
    logic [1:0]  addr3;
    logic [1:0]  thread;
    logic [1:0]  outsel;
    logic        issue_valid;
    logic        dout_valid;
    logic [1:0]  dout_thread;
    logic [3:0]  thread_idle;

    modport master (
        output cmd_valid, cmd_thread, cmd_data, stall,
        input  cmd_ready, mode1, mode2, mode3, addr2, addr3, thread, outsel,
               issue_valid, dout_valid, dout_thread, thread_idle
    );

    modport slave (
        input  cmd_valid, cmd_thread, cmd_data, stall,
        output cmd_ready, mode1, mode2, mode3, addr2, addr3, thread, outsel,
               issue_valid, dout_valid, dout_thread, thread_idle
    );
endinterface

// File: rtl/postadder_seq.sv
// postadder_seq: per-thread command FIFOs, round-robin issue and latency tracking for the BN254 post-adder
module postadder_seq #(
    parameter int DEPTH = 4,
    parameter int NTHR  = 4
) (
    input  logic clk,
    input  logic rst,
    postadder_seq_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [15:0]     mem [NTHR][DEPTH];
    logic [AW:0]     wp [NTHR];
    logic [AW:0]     rp [NTHR];
    logic [NTHR-1:0] empty, full, elig, idle;
    logic [1:0]      rr, gt, cand, out_thr;
    logic            gnt, push, iss_emit, out_v, out_emit, res_v;
    logic [1:0]      iss_os;
    logic [15:0]     pop_d;

    assign push          = bus.cmd_valid & bus.cmd_ready;
    assign bus.cmd_ready = !full[bus.cmd_thread];
    assign pop_d         = mem[gt][rp[gt][AW-1:0]];
    assign bus.thread_idle = idle;

    // FIFO flags from registered pointers; the extra MSB separates full from empty
    always_comb begin
        empty = '0;
        full  = '0;
        for (int i = 0; i < NTHR; i++) begin
            empty[i] = wp[i] == rp[i];
            full[i]  = wp[i] == {~rp[i][AW], rp[i][AW-1:0]};
        end
        elig = bus.stall ? '0 : ~empty;
    end

    // Round-robin grant: first eligible thread after the last winner
    always_comb begin
        gnt  = 1'b0;
        gt   = rr;
        cand = '0;
        for (int i = 1; i <= NTHR; i++) begin
            cand = rr + 2'(i);
            if (!gnt && elig[cand]) begin
                gnt = 1'b1;
                gt  = cand;
            end
        end
    end

    // A thread is idle once its FIFO and every pipeline stage are free of its commands
    always_comb begin
        idle = '0;
        for (int i = 0; i < NTHR; i++)
            idle[i] = empty[i] && !(bus.issue_valid && bus.thread == 2'(i))
                    && !(out_v && out_thr == 2'(i)) && !(res_v && bus.dout_thread == 2'(i));
    end

    // Command storage, written without reset since pointers define validity
    always_ff @(posedge clk) begin
        if (push)
            mem[bus.cmd_thread][wp[bus.cmd_thread][AW-1:0]] <= bus.cmd_data;
    end

    // FIFO pointers and round-robin state
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NTHR; i++) begin
                wp[i] <= '0;
                rp[i] <= '0;
            end
            rr <= 2'd3;
        end else begin
            if (push)
                wp[bus.cmd_thread] <= wp[bus.cmd_thread] + 1'b1;
            if (gnt) begin
                rp[gt] <= rp[gt] + 1'b1;
                rr     <= gt;
            end
        end
    end

    // Issue, output and result stages; a no-grant cycle issues the mode-000 NOP
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.issue_valid <= 1'b0;
            bus.mode1       <= '0;
            bus.mode2       <= '0;
            bus.mode3       <= '0;
            bus.addr2       <= '0;
            bus.addr3       <= '0;
            bus.thread      <= '0;
            bus.outsel      <= '0;
            bus.dout_valid  <= 1'b0;
            bus.dout_thread <= '0;
            iss_emit        <= 1'b0;
            iss_os          <= '0;
            out_v           <= 1'b0;
            out_emit        <= 1'b0;
            out_thr         <= '0;
            res_v           <= 1'b0;
        end else begin
            bus.issue_valid <= gnt;
            bus.mode1       <= gnt ? pop_d[2:0]   : 3'd0;
            bus.mode2       <= gnt ? pop_d[5:3]   : 3'd0;
            bus.mode3       <= gnt ? pop_d[8:6]   : 3'd0;
            bus.addr2       <= gnt ? pop_d[10:9]  : 2'd0;
            bus.addr3       <= gnt ? pop_d[12:11] : 2'd0;
            bus.thread      <= gnt ? gt : bus.thread;
            iss_emit        <= gnt & pop_d[15];
            iss_os          <= pop_d[14:13];
            out_v           <= bus.issue_valid;
            out_emit        <= iss_emit;
            out_thr         <= bus.thread;
            bus.outsel      <= iss_emit ? iss_os : bus.outsel;
            res_v           <= out_v;
            bus.dout_valid  <= out_emit;
            bus.dout_thread <= out_v ? out_thr : bus.dout_thread;
        end
    end
endmodule

// File: tb/tb_postadder_seq.sv
// tb_postadder_seq: directed and random stimulus against a queue-based model of the sequencer
module tb_postadder_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    postadder_seq_if bus();
    postadder_seq dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        bit          v;
        logic [15:0] d;
        logic [1:0]  t;
    } ent_t;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] q [4][$];
    ent_t        hist [3];
    int          rr;
    logic [1:0]  e_thr, e_outsel;
    bit          last_acc;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [3:0] idle;
        ent_t h0, h2;
        h0 = hist[0];
        h2 = hist[2];
        for (int t = 0; t < 4; t++) begin
            idle[t] = q[t].size() == 0;
            for (int k = 0; k < 3; k++)
                if (hist[k].v && hist[k].t == 2'(t)) idle[t] = 1'b0;
        end
        chk("cmd_ready", 16'(bus.cmd_ready), 16'(q[bus.cmd_thread].size() < 4));
        chk("issue_valid", 16'(bus.issue_valid), 16'(h0.v));
        chk("mode1", 16'(bus.mode1), h0.v ? 16'(h0.d[2:0]) : 16'd0);
        chk("mode2", 16'(bus.mode2), h0.v ? 16'(h0.d[5:3]) : 16'd0);
        chk("mode3", 16'(bus.mode3), h0.v ? 16'(h0.d[8:6]) : 16'd0);
        chk("addr2", 16'(bus.addr2), h0.v ? 16'(h0.d[10:9]) : 16'd0);
        chk("addr3", 16'(bus.addr3), h0.v ? 16'(h0.d[12:11]) : 16'd0);
        chk("thread", 16'(bus.thread), 16'(e_thr));
        chk("outsel", 16'(bus.outsel), 16'(e_outsel));
        chk("dout_valid", 16'(bus.dout_valid), 16'(h2.v && h2.d[15]));
        if (h2.v && h2.d[15]) chk("dout_thread", 16'(bus.dout_thread), 16'(h2.t));
        chk("thread_idle", 16'(bus.thread_idle), 16'(idle));
    endtask

    task automatic model_step();
        ent_t n;
        int g;
        n = '{default: 0};
        last_acc = 1'b0;
        if (rst) begin
            for (int t = 0; t < 4; t++) q[t].delete();
            for (int k = 0; k < 3; k++) hist[k] = '{default: 0};
            rr = 3;
            e_thr = 2'd0;
            e_outsel = 2'd0;
            return;
        end
        last_acc = bus.cmd_valid && q[bus.cmd_thread].size() < 4;
        if (!bus.stall)
            for (int i = 1; i <= 4; i++) begin
                g = (rr + i) % 4;
                if (q[g].size() > 0) begin
                    n.v = 1'b1;
                    n.t = 2'(g);
                    n.d = q[g].pop_front();
                    rr = g;
                    break;
                end
            end
        if (last_acc) q[bus.cmd_thread].push_back(bus.cmd_data);
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = n;
        if (n.v) e_thr = n.t;
        if (hist[1].v && hist[1].d[15]) e_outsel = hist[1].d[14:13];
    endtask

    task automatic step();
        @(negedge clk);
        check_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int t, input logic [15:0] d, input bit s);
        bus.cmd_valid = v;
        bus.cmd_thread = 2'(t);
        bus.cmd_data = d;
        bus.stall = s;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 16'h0, 0);
        model_step();
        @(posedge clk);
        #1;
        step();
        rst = 1'b0;
        chk("reset_idle", 16'(bus.thread_idle), 16'hf);
        chk("reset_ready", 16'(bus.cmd_ready), 16'd1);

        drive(1, 1, 16'h8012, 0);
        step();
        drive(0, 0, 16'h0, 0);
        step();
        chk("single_issue", 16'(bus.issue_valid), 16'd1);
        chk("single_thread", 16'(bus.thread), 16'd1);
        chk("single_mode1", 16'(bus.mode1), 16'd2);
        step();
        chk("single_outsel", 16'(bus.outsel), 16'd0);
        step();
        chk("single_dout", 16'({bus.dout_valid, bus.dout_thread}), 16'b101);
        step();
        chk("single_idle", 16'(bus.thread_idle), 16'hf);

        for (int i = 0; i < 4; i++) begin
            drive(1, 2, 16'($urandom), 1);
            step();
        end
        drive(1, 2, 16'h1234, 1);
        #1;
        chk("full_ready", 16'(bus.cmd_ready), 16'd0);
        step();
        chk("stall_nop", 16'({bus.issue_valid, bus.mode1, bus.mode2, bus.mode3}), 16'd0);
        drive(0, 0, 16'h0, 0);
        for (int i = 0; i < 7; i++) step();

        foreach (q[i]) ;
        for (int i = 0; i < 6; i++) begin
            drive(1, (i % 3 == 2) ? 3 : i % 3, 16'h8000 | 16'($urandom_range(0, 16'h7fff)), 0);
            step();
        end
        drive(0, 0, 16'h0, 0);
        for (int i = 0; i < 5; i++) step();

        drive(1, 0, 16'h4000, 0);
        step();
        drive(1, 0, 16'hA000, 0);
        step();
        drive(0, 0, 16'h0, 0);
        for (int i = 0; i < 5; i++) step();

        for (int i = 0; i < 5; i++) begin
            drive(1, (i < 3) ? 3 : 1, 16'($urandom), 1);
            step();
        end
        drive(0, 0, 16'h0, 0);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_idle", 16'(bus.thread_idle), 16'hf);
        chk("midrst_issue", 16'(bus.issue_valid), 16'd0);
        drive(1, 2, 16'h8001, 1);
        step();
        drive(1, 0, 16'h8002, 1);
        step();
        drive(0, 0, 16'h0, 0);
        step();
        chk("post_rst_grant", 16'({bus.issue_valid, bus.thread}), 16'b100);
        for (int i = 0; i < 5; i++) step();

        begin
            bit rv = 0;
            int rt = 0;
            logic [15:0] rd = '0;
            for (int i = 0; i < 400; i++) begin
                if (!rv || last_acc) begin
                    rv = $urandom_range(0, 3) != 0;
                    rt = $urandom_range(0, 3);
                    rd = 16'($urandom);
                end
                rst = (i == 200);
                drive(rv, rt, rd, $urandom_range(0, 4) == 0);
                step();
            end
        end
        rst = 1'b0;
        drive(0, 0, 16'h0, 0);
        for (int i = 0; i < 20; i++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
